// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbitration logic.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StSend      = 3'd1,
    StWaitStart = 3'd2,
    StWaitDone  = 3'd3,
    StFinish    = 3'd4
  } state_e;

  // Bit 'pos' of the one-hot vector selected by 'idx'.
  function automatic logic onehot_bit(input logic [2:0] idx, input int unsigned pos);
    return (32'(idx) == pos);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i, wrapping.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int unsigned IW = $clog2(N);

  int unsigned cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_i) + k) % N;
      if (!valid_o && req_i[cand[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx channel among N_REQ byte producers,
// with a watchdog on the send -> frame-start handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned START_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         err,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  input  logic                     ready_tx,
  output logic                     send,
  output logic [7:0]               data_o
);

  localparam int unsigned TO_W  = $clog2(START_TIMEOUT + 1);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic               ready_m_q, ready_s_q;
  logic [N_REQ-1:0]   grant_oh;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .req_i   (req),
    .last_i  (grant_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_m_q <= 1'b0;
      ready_s_q <= 1'b0;
      state_q   <= StIdle;
      grant_q   <= IDX_W'(N_REQ - 1);
      data_q    <= 8'h00;
      cnt_q     <= '0;
      err_q     <= '0;
    end else begin
      ready_m_q <= ready_tx;
      ready_s_q <= ready_m_q;
      state_q   <= state_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      grant_oh[i] = onehot_bit(3'(grant_q), i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = '0;
    send    = 1'b0;
    ack     = '0;
    case (state_q)
      StIdle: begin
        // No grant while the transmitter is still busy with a previous frame.
        if (ready_s_q && pick_valid) begin
          grant_d = pick_idx;
          data_d  = req_data[{pick_idx, 3'b000} +: 8];
          state_d = StSend;
        end
      end
      StSend: begin
        send    = 1'b1;
        cnt_d   = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        cnt_d = cnt_q + TO_W'(1);
        // A frame start seen on the limit cycle takes priority over the timeout.
        if (!ready_s_q) begin
          state_d = StWaitDone;
        end else if (cnt_q == TO_W'(START_TIMEOUT - 1)) begin
          err_d   = grant_oh;
          state_d = StIdle;
        end else begin
          send = 1'b1;
        end
      end
      StWaitDone: begin
        if (ready_s_q) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        ack     = grant_oh;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign err      = err_q;
  assign grant_id = grant_q;
  assign data_o   = data_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmit channel (data_i/send/ready_tx of uart_transceiver) among N_REQ byte-producing requesters using round-robin arbitration.
- Sequences each byte through the transmitter's handshake: raise send, wait for ready_tx to fall (frame started), wait for ready_tx to rise (frame done), then acknowledge the requester.
- Holds the granted byte stable for the whole frame, because uart_tx samples data only in its START state on a clk_uart edge.
- Includes a start-timeout watchdog for a stalled or disabled baud clock.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 1024, clk cycles allowed between send assertion and ready_tx falling; must be at least 2.
- TO_W, $clog2(START_TIMEOUT+1), timeout counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, same clock as uart_tx clk.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request; held high with data stable until ack or err.
- req_data  input  8*N_REQ  byte of requester i at [8*i+7:8*i].
- ack  output  N_REQ  one-cycle pulse: requester's byte fully transmitted.
- err  output  N_REQ  one-cycle pulse: requester's byte aborted by start timeout.
- grant_id  output  $clog2(N_REQ)  index of the current/last granted requester.
- busy  output  1  high in every state except IDLE.
- ready_tx  input  1  from uart_tx ready (high = READY state).
- send  output  1  to uart_tx send.
- data_o  output  8  to uart_tx data_i.

Behaviour:
- Reset values: state=IDLE, send=0, data_o=8'h00, ack=0, err=0, busy=0, grant_id=N_REQ-1 (so the first search starts at 0), timeout counter=0. Reset mid-frame returns to IDLE immediately; the transmitter is not aborted.
- All logic is synchronous to posedge clk apart from the reset. ready_tx comes from the clk_uart domain and is passed through a 2-flop synchronizer before use (ready_s).
- FSM states: IDLE, SEND, WAIT_START, WAIT_DONE, FINISH.
- IDLE: if ready_s=1 and req!=0, select the first set req bit searching grant_id+1, grant_id+2, … modulo N_REQ. Latch the index into grant_id and the byte into data_o, then go to SEND. If ready_s=0, stay in IDLE; no grant is issued while the transmitter is busy.
- SEND: send=1, timeout counter cleared, then go to WAIT_START. Send stays high until ready_s is seen low.
- WAIT_START: send=1; counter increments every cycle.
  - If ready_s=0: send=0, go to WAIT_DONE.
  - Else if counter reaches START_TIMEOUT-1: send=0, err[grant_id] pulses for 1 cycle, go to IDLE. data_o is retained.
  - If both occur in the same cycle, ready_s=0 wins (no err).
- WAIT_DONE: send=0 and data_o held. When ready_s=1, go to FINISH. There is no timeout here; frame length is bounded by the transmitter.
- FINISH: ack[grant_id] pulses for 1 cycle, then go to IDLE. The next grant can be issued at the earliest in the following cycle.
- Latency, req to send: 2 clk cycles after req is seen (IDLE→SEND, send high in SEND) when ready_s=1.
- At most one ack/err bit is high at any time, and never both.
- req changes while granted are ignored; req_data is not re-sampled after IDLE.
- A requester that drops req before being granted is simply skipped.
- Fairness: with all req high, grants cycle 0,1,…,N_REQ-1,0. A lone requester is re-granted back-to-back.
- Illegal state encoding → IDLE.

Decomposition:
- Shared package (uart_pkg): FSM state encoding localparams, and a ONEHOT/index helper function.
- One sub-module, rr_pick: a combinational round-robin priority picker.
  - Inputs: req vector, last index.
  - Outputs: valid, index.
  - Reusable for a future RX-side distributor.
- The ready_tx synchronizer is inline.

Test Plan:
- Single request: ready_tx=1, req=4'b0010, req_data[15:8]=8'hA5.
  - Required: send rises 2 cycles later and data_o=8'hA5; send drops once ready_tx is driven low; after ready_tx returns high, ack=4'b0010 for 1 cycle and grant_id=1.
  - Also check with a real uart_tx model that serial frame 0x A5 appears on tx.
- Round robin: req=4'b1111 held continuously, each frame completed by the model.
  - Required: grant order 0,1,2,3,0 and ack pulses in that order; data_o matches each requester's byte.
- Transmitter busy at request: ready_tx=0, req=4'b0001.
  - Required: no send while ready_tx=0; grant occurs within 4 cycles of ready_tx rising.
- Start timeout: START_TIMEOUT=16, ready_tx stuck at 1, req=4'b0100.
  - Required: send high for exactly 16 cycles; err=4'b0100 pulses; ack stays 0; FSM returns to IDLE and re-grants 2 if req is still high.
- Reset mid-frame: assert rst during WAIT_DONE.
  - Required: send=0, busy=0, ack=0, grant_id=N_REQ-1 asynchronously; after release, a new req on 0 is granted first.
- Simultaneous timeout and start: ready_tx falls in the same cycle the counter hits its limit.
  - Required: no err; FSM goes to WAIT_DONE and ack follows normally.
